// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the iterative RV32M divider.
package div_pkg;

  localparam int unsigned DIV_XLEN  = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_ITERS);

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [DIV_XLEN-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
  localparam logic [DIV_XLEN-1:0] INT_MIN      = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // funct3[0] clear means the op treats operands as two's complement
  function automatic logic op_is_signed(input logic [1:0] i_op);
    return ~i_op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] i_op);
    return i_op[1];
  endfunction

  function automatic logic [DIV_XLEN-1:0] neg_if(input logic i_neg,
                                                 input logic [DIV_XLEN-1:0] i_val);
    return i_neg ? (~i_val + DIV_XLEN'(1)) : i_val;
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the operand-select stage and the divider.
interface div_if
  import div_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
);

  logic            i_start;
  logic [1:0]      i_div_op;
  logic [XLEN-1:0] i_operand_a;
  logic [XLEN-1:0] i_operand_b;
  logic            i_flush;
  logic            o_ready;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_div_op, i_operand_a, i_operand_b, i_flush,
    input  o_ready, o_valid, o_result
  );

  modport slave (
    input  i_start, i_div_op, i_operand_a, i_operand_b, i_flush,
    output o_ready, o_valid, o_result
  );

endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// divide-by-zero and signed overflow resolved at acceptance.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic i_clk,
  input  logic i_rst_n,
  div_if.slave bus
);

  div_state_e            r_state;
  div_state_e            w_state_nxt;
  logic [DIV_CNT_W-1:0]  r_cnt;
  logic                  r_is_rem;
  logic                  r_neg_quo;
  logic                  r_neg_rem;
  logic [XLEN-1:0]       r_divisor;
  logic [XLEN-1:0]       r_rem;
  logic [XLEN-1:0]       r_quo;
  logic [XLEN-1:0]       r_result;

  logic                  w_accept;
  logic                  w_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [XLEN-1:0]       w_mag_a;
  logic [XLEN-1:0]       w_mag_b;
  logic                  w_div_zero;
  logic                  w_overflow;
  logic [XLEN-1:0]       w_special_res;
  logic [XLEN:0]         w_shift;
  logic [XLEN:0]         w_trial;
  logic                  w_keep;
  logic [XLEN-1:0]       w_rem_nxt;
  logic [XLEN-1:0]       w_quo_nxt;
  logic [XLEN-1:0]       w_final_res;
  logic                  w_load;
  logic                  w_step;
  logic                  w_res_we;
  logic [XLEN-1:0]       w_res_d;

  // Acceptance-time decode of the request
  assign w_accept   = (r_state == IDLE) && bus.i_start && !bus.i_flush;
  assign w_signed   = op_is_signed(bus.i_div_op);
  assign w_a_neg    = w_signed && bus.i_operand_a[XLEN-1];
  assign w_b_neg    = w_signed && bus.i_operand_b[XLEN-1];
  assign w_mag_a    = neg_if(w_a_neg, bus.i_operand_a);
  assign w_mag_b    = neg_if(w_b_neg, bus.i_operand_b);
  assign w_div_zero = (bus.i_operand_b == '0);
  assign w_overflow = w_signed && (bus.i_operand_a == INT_MIN) && (bus.i_operand_b == '1);

  always_comb begin
    w_special_res = op_is_rem(bus.i_div_op) ? XLEN'(0) : INT_MIN;
    if (w_div_zero) begin
      w_special_res = op_is_rem(bus.i_div_op) ? bus.i_operand_a : DIV_ZERO_QUO;
    end
  end

  // Restoring step; a carry into the shifted top bit always means the divisor fits
  assign w_shift     = {r_rem, r_quo[XLEN-1]};
  assign w_trial     = w_shift - {1'b0, r_divisor};
  assign w_keep      = w_shift[XLEN] || !w_trial[XLEN];
  assign w_rem_nxt   = w_keep ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt   = {r_quo[XLEN-2:0], w_keep};
  assign w_final_res = r_is_rem ? neg_if(r_neg_rem, w_rem_nxt) : neg_if(r_neg_quo, w_quo_nxt);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_res_we    = 1'b0;
    w_res_d     = r_result;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (w_div_zero || w_overflow) begin
            w_state_nxt = DONE;
            w_res_we    = 1'b1;
            w_res_d     = w_special_res;
          end else begin
            w_state_nxt = CALC;
          end
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == DIV_CNT_W'(DIV_ITERS - 1)) begin
          w_state_nxt = DONE;
          w_res_we    = 1'b1;
          w_res_d     = w_final_res;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Abort wins over everything, including the final CALC step
    if (bus.i_flush) begin
      w_state_nxt = IDLE;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_res_we    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_is_rem  <= 1'b0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_result  <= '0;
    end else begin
      if (w_load) begin
        r_cnt     <= '0;
        r_is_rem  <= op_is_rem(bus.i_div_op);
        r_neg_quo <= w_a_neg ^ w_b_neg;
        r_neg_rem <= w_a_neg;
        r_divisor <= w_mag_b;
        r_rem     <= '0;
        r_quo     <= w_mag_a;
      end else if (w_step) begin
        r_cnt <= r_cnt + DIV_CNT_W'(1);
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
      end
      if (w_res_we) begin
        r_result <= w_res_d;
      end
    end
  end

  assign bus.o_ready  = (r_state == IDLE);
  assign bus.o_valid  = (r_state == DONE);
  assign bus.o_result = r_result;

endmodule
